// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its picker.
package fifo_arb_pkg;

   localparam int unsigned WIDTH_DEF   = 8;
   localparam int unsigned NUM_REQ_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Priority pointer that starts just after the given owner, wrapping at num_req.
   function automatic int unsigned next_rr_ptr(input int unsigned owner,
                                               input int unsigned num_req);
      return (owner + 1) % num_req;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning upward from start.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    start,
   output logic [ID_W-1:0]    winner,
   output logic               any_valid
);

   int unsigned idx;

   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      idx       = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(start) + i) % NUM_REQ;
         if (!any_valid && req[ID_W'(idx)]) begin
            any_valid = 1'b1;
            winner    = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with a bounded burst per grant and zero-latency accept.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] wdata_in,
   output logic [NUM_REQ-1:0]       gnt,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [WIDTH-1:0]         fifo_wdata,
   output logic                     owner_valid,
   output logic [ID_W-1:0]          owner_id,
   output logic                     stall
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e       state;
   logic [ID_W-1:0]  rr_ptr;
   logic [CNT_W-1:0] burst_cnt;
   logic [ID_W-1:0]  pick_id;
   logic             pick_valid;
   logic             owner_req;
   logic             accept;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req       (req),
      .start     (rr_ptr),
      .winner    (pick_id),
      .any_valid (pick_valid)
   );

   // Accept path is combinational so data is written in the cycle gnt is high.
   assign owner_req   = req[owner_id];
   assign owner_valid = (state == BURST) & ~rst;
   assign accept      = owner_valid & owner_req & ~fifo_full;
   assign stall       = owner_valid & owner_req & fifo_full;
   assign fifo_wr_en  = accept;
   assign fifo_wdata  = wdata_in[32'(owner_id) * WIDTH +: WIDTH];

   always_comb begin
      gnt           = '0;
      gnt[owner_id] = accept;
   end

   // Owner is held through full stalls; it leaves on req drop or on the final burst accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner_id  <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  owner_id  <= pick_id;
                  burst_cnt <= '0;
                  state     <= BURST;
               end
            end
            BURST: begin
               if (!owner_req) begin
                  state  <= IDLE;
                  rr_ptr <= ID_W'(next_rr_ptr(32'(owner_id), NUM_REQ));
               end else if (accept) begin
                  burst_cnt <= burst_cnt + CNT_W'(1);
                  if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                     state  <= IDLE;
                     rr_ptr <= ID_W'(next_rr_ptr(32'(owner_id), NUM_REQ));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
